// File: rtl/leta_pkg.sv
// Shared definitions for the quadrature front end.
//   step_t      : per-cycle decoder result for one channel
//   step_decode : maps {previous {A,B}, current {A,B}} to a step code
package leta_pkg;

  localparam int RD_W         = 8;  // width of the CPU read value
  localparam int MAX_CHANNELS = 8;  // size of the addressable read window

  // Codes are chosen so that (position(cur) - position(prev)) mod 4 along
  // the Gray sequence 00 -> 10 -> 11 -> 01 is the step code itself:
  // 0 = no move, 1 = one step forward, 3 = one step back, 2 = both bits flipped.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_ERR  = 2'd2,
    STEP_DN   = 2'd3
  } step_t;

  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;  // 2'b01
    endcase
  endfunction

  // pair = {prev_a, prev_b, cur_a, cur_b}
  function automatic step_t step_decode(input logic [3:0] pair);
    logic [1:0] delta;
    delta = gray_pos(pair[1:0]) - gray_pos(pair[3:2]);
    return step_t'(delta);
  endfunction

endpackage

// File: rtl/quad_leta_array_if.sv
// Player-input / CPU-read bundle of the quadrature front end.
//   a, b   : raw quadrature phases per channel (asynchronous)
//   clear  : per-channel counter/error clear pulse
//   latch  : snapshot strobe
//   addr   : channel select for the read port
//   data   : registered 8-bit read value
//   err    : sticky illegal-transition flags
// master = the side driving pins and address, slave = the front end.
interface quad_leta_array_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] a;
  logic [CHANNELS-1:0] b;
  logic [CHANNELS-1:0] clear;
  logic                latch;
  logic [2:0]          addr;
  logic [7:0]          data;
  logic [CHANNELS-1:0] err;

  modport master (output a, b, clear, latch, addr, input data, err);
  modport slave  (input a, b, clear, latch, addr, output data, err);
endinterface

// File: rtl/quad_channel.sv
// One quadrature channel: 2-FF synchroniser and glitch filter on A and B,
// priming, step decode, up/down counter (wrap or saturate) and sticky error.
//   clk, reset : system clock, synchronous active-high reset
//   a, b       : raw phases (asynchronous)
//   clear      : zero counter and error (wins over a same-cycle update)
//   rd_slice   : counter[OUT_SHIFT+7:OUT_SHIFT] for the read port
//   err        : sticky illegal-transition flag
module quad_channel
  import leta_pkg::*;
#(
  parameter int CNT_W     = 9,
  parameter int OUT_SHIFT = 1,
  parameter int FILT      = 2,
  parameter int SATURATE  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a,
  input  logic            b,
  input  logic            clear,
  output logic [RD_W-1:0] rd_slice,
  output logic            err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit               SAT     = (SATURATE != 0);

  logic [1:0]       sync1, sync2, filt, prev;
  logic             vld1, vld2, primed;
  logic [CNT_W-1:0] cnt;
  step_t            step;

  // vld1/vld2 mark when sync2 holds a sampled pin value rather than reset 00,
  // so priming never latches the reset value of the pipeline.
  // NOTE: clocked state uses <= throughout so every right-hand side reads the
  // pre-edge value; a blocking = here would collapse the two sync stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      vld1  <= 1'b0;
      vld2  <= 1'b0;
    end else begin
      sync1 <= {a, b};
      sync2 <= sync1;
      vld1  <= 1'b1;
      vld2  <= vld1;
    end
  end

  // Each phase is filtered on its own. Until the channel is primed the level
  // follows the synchroniser directly: there is no established level to guard.
  for (genvar j = 0; j < 2; j++) begin : g_filt
    logic lvl;
    assign filt[j] = lvl;

    if (FILT == 0) begin : g_pass
      always_ff @(posedge clk) begin
        if (reset) lvl <= 1'b0;
        else       lvl <= sync2[j];
      end
    end else begin : g_run
      localparam int             RUN_W   = $clog2(FILT + 1);
      localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILT);
      logic [RUN_W-1:0] run;

      // run counts cycles the input has disagreed with lvl; the level flips
      // on the edge after FILT disagreeing cycles, so pulses <= FILT vanish.
      always_ff @(posedge clk) begin
        if (reset) begin
          lvl <= 1'b0;
          run <= '0;
        end else if (!primed || sync2[j] == lvl) begin
          lvl <= sync2[j];
          run <= '0;
        end else if (run == RUN_MAX) begin
          lvl <= sync2[j];
          run <= '0;
        end else begin
          run <= run + RUN_W'(1);
        end
      end
    end
  end

  assign step = step_decode({prev, filt});

  always_ff @(posedge clk) begin
    if (reset) begin
      prev   <= 2'b00;
      primed <= 1'b0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      // Priming loads prev and the filter level from the same sample, so the
      // first comparison after priming is always "no change".
      if (!primed) begin
        if (vld2) begin
          prev   <= sync2;
          primed <= 1'b1;
        end
      end else begin
        prev <= filt;
      end

      if (clear) begin
        cnt <= '0;
        err <= 1'b0;
      end else if (primed) begin
        case (step)
          STEP_UP:  if (!(SAT && cnt == CNT_MAX)) cnt <= cnt + CNT_W'(1);
          STEP_DN:  if (!(SAT && cnt == '0))      cnt <= cnt - CNT_W'(1);
          STEP_ERR: err <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

  assign rd_slice = cnt[OUT_SHIFT +: RD_W];

endmodule

// File: rtl/quad_leta_array.sv
// Multi-channel quadrature/trackball front end. Instantiates CHANNELS
// quad_channel blocks, optional snapshot registers and the registered
// CPU read mux.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : quad_leta_array_if slave (pins, clear, latch, addr, data, err)
module quad_leta_array
  import leta_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 9,
  parameter int OUT_SHIFT = 1,
  parameter int FILT      = 2,
  parameter int SATURATE  = 0,
  parameter int LATCHED   = 0
) (
  input  logic          clk,
  input  logic          reset,
  quad_leta_array_if.slave bus
);

  logic [RD_W-1:0] live    [CHANNELS];
  logic [RD_W-1:0] src     [CHANNELS];
  logic [RD_W-1:0] rd_word [MAX_CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    quad_channel #(
      .CNT_W     (CNT_W),
      .OUT_SHIFT (OUT_SHIFT),
      .FILT      (FILT),
      .SATURATE  (SATURATE)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .a        (bus.a[i]),
      .b        (bus.b[i]),
      .clear    (bus.clear[i]),
      .rd_slice (live[i]),
      .err      (bus.err[i])
    );
  end

  if (LATCHED != 0) begin : g_snap
    // All channels capture on the same edge; live[] is the pre-edge count,
    // so a step landing on the latch edge is not in the snapshot.
    // NOTE: the snapshots are a handful of flops, not a RAM, so they take the
    // reset like any other register.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < CHANNELS; k++) src[k] <= '0;
      end else if (bus.latch) begin
        for (int k = 0; k < CHANNELS; k++) src[k] <= live[k];
      end
    end
  end else begin : g_live
    assign src = live;
  end

  // Padding the window to eight entries makes out-of-range addresses read 0.
  for (genvar w = 0; w < MAX_CHANNELS; w++) begin : g_word
    if (w < CHANNELS) begin : g_used
      assign rd_word[w] = src[w];
    end else begin : g_empty
      assign rd_word[w] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bus.data <= '0;
    else       bus.data <= rd_word[bus.addr];
  end

endmodule

// File: tb/tb_quad_leta_array.sv
// Directed bench for quad_leta_array. Two instances share clk/reset:
//   u_wrap : FILT=2, wrap mode, live reads
//   u_sat  : FILT=0, saturating, snapshot reads
// Inputs change and outputs are sampled on the falling edge.
module tb_quad_leta_array;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   pos_w [4];
  int   pos_s [4];

  quad_leta_array_if #(.CHANNELS(4)) if_w ();
  quad_leta_array_if #(.CHANNELS(4)) if_s ();

  quad_leta_array #(
    .CHANNELS(4), .CNT_W(9), .OUT_SHIFT(1), .FILT(2), .SATURATE(0), .LATCHED(0)
  ) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (if_w)
  );

  quad_leta_array #(
    .CHANNELS(4), .CNT_W(9), .OUT_SHIFT(1), .FILT(0), .SATURATE(1), .LATCHED(1)
  ) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (if_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Position along the forward Gray sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Steps spaced 1+FILT cycles (the maximum countable rate).
  task automatic step_w(input int ch, input int dir, input int n);
    logic [1:0] ab;
    for (int k = 0; k < n; k++) begin
      pos_w[ch] = (pos_w[ch] + dir + 4) % 4;
      ab = gray(pos_w[ch]);
      if_w.a[ch] = ab[1];
      if_w.b[ch] = ab[0];
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic step_s(input int ch, input int dir, input int n);
    logic [1:0] ab;
    for (int k = 0; k < n; k++) begin
      pos_s[ch] = (pos_s[ch] + dir + 4) % 4;
      ab = gray(pos_s[ch]);
      if_s.a[ch] = ab[1];
      if_s.b[ch] = ab[0];
      @(negedge clk);
    end
  endtask

  task automatic rd_w(input logic [2:0] ad, output logic [7:0] d);
    if_w.addr = ad;
    @(negedge clk);
    d = if_w.data;
  endtask

  task automatic rd_s(input logic [2:0] ad, output logic [7:0] d);
    if_s.addr = ad;
    @(negedge clk);
    d = if_s.data;
  endtask

  task automatic latch_s();
    if_s.latch = 1'b1;
    @(negedge clk);
    if_s.latch = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] seen;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 4; i++) begin
      pos_w[i] = 2;
      pos_s[i] = 2;
    end
    reset = 1'b1;
    if_w.a = 4'hF; if_w.b = 4'hF; if_w.clear = 4'h0; if_w.latch = 1'b0; if_w.addr = 3'd0;
    if_s.a = 4'hF; if_s.b = 4'hF; if_s.clear = 4'h0; if_s.latch = 1'b0; if_s.addr = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_data", {8'h00, if_w.data}, 16'h0000);
    check("reset_err", {12'h000, if_w.err}, 16'h0000);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Held at 11 through priming: nothing counted, nothing flagged.
    rd_w(3'd0, d);
    check("prime_data", {8'h00, d}, 16'h0000);
    check("prime_err", {12'h000, if_w.err}, 16'h0000);

    // 8 forward -> count 8 -> 8'h04; 10 back -> 9'h1FE -> 8'hFF.
    step_w(0, 1, 8);
    repeat (8) @(negedge clk);
    rd_w(3'd0, d);
    check("fwd8", {8'h00, d}, 16'h0004);
    step_w(0, -1, 10);
    repeat (8) @(negedge clk);
    rd_w(3'd0, d);
    check("wrap_rev10", {8'h00, d}, 16'h00FF);
    check("legal_err", {12'h000, if_w.err}, 16'h0000);

    // 2-cycle glitch on ch2 (11 -> 10 -> 11). If it got through, the count
    // would dip to 1FF and show FF on the read port for a few cycles.
    if_w.addr = 3'd2;
    @(negedge clk);
    if_w.b[2] = 1'b0;
    repeat (2) @(negedge clk);
    if_w.b[2] = 1'b1;
    seen = 8'h00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen = seen | if_w.data;
    end
    check("glitch_reject", {8'h00, seen}, 16'h0000);

    // Stable -1 on ch2 driven before edge E1: counter moves on E1+5, so the
    // read port still shows 00 after E6 and FF after E7.
    if_w.b[2] = 1'b0;
    pos_w[2] = 1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) check("lat_pre", {8'h00, if_w.data}, 16'h0000);
      if (k == 7) check("lat_post", {8'h00, if_w.data}, 16'h00FF);
    end

    // ch3: both phases flip together -> sticky err, no count.
    if_w.a[3] = 1'b0;
    if_w.b[3] = 1'b0;
    repeat (10) @(negedge clk);
    check("err_set", {12'h000, if_w.err}, 16'h0008);
    rd_w(3'd3, d);
    check("err_nocount", {8'h00, d}, 16'h0000);

    // ch3: -1 step (00 -> 01) lands on E6 together with clear.
    if_w.b[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) if_w.clear[3] = 1'b1;
      if (k == 6) if_w.clear[3] = 1'b0;
    end
    repeat (6) @(negedge clk);
    rd_w(3'd3, d);
    check("clear_cnt", {8'h00, d}, 16'h0000);
    check("clear_err", {12'h000, if_w.err}, 16'h0000);

    // Saturating instance, ch0: 3 back from 0 stays 0.
    step_s(0, -1, 3);
    repeat (6) @(negedge clk);
    latch_s();
    rd_s(3'd0, d);
    check("sat_low", {8'h00, d}, 16'h0000);
    // 600 forward clamps at 9'h1FF -> 8'hFF (wrapping would give 8'h2C).
    step_s(0, 1, 600);
    repeat (6) @(negedge clk);
    latch_s();
    rd_s(3'd0, d);
    check("sat_high", {8'h00, d}, 16'h00FF);

    // ch1: count 3, then a 4th step lands on the latch edge (E1+3).
    step_s(1, 1, 3);
    repeat (6) @(negedge clk);
    pos_s[1] = (pos_s[1] + 1) % 4;
    {if_s.a[1], if_s.b[1]} = gray(pos_s[1]);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) if_s.latch = 1'b1;
      if (k == 4) if_s.latch = 1'b0;
    end
    rd_s(3'd1, d);
    check("snap_pre_step", {8'h00, d}, 16'h0001);
    latch_s();
    rd_s(3'd1, d);
    check("snap_post_step", {8'h00, d}, 16'h0002);
    rd_s(3'd0, d);
    check("snap_ch0", {8'h00, d}, 16'h00FF);
    rd_s(3'd4, d);
    check("addr_oob", {8'h00, d}, 16'h0000);
    check("sat_err", {12'h000, if_s.err}, 16'h0000);

    // Mid-run reset: read register cleared at once, counts gone, and the
    // non-11 pin levels left on ch0/ch2/ch3 re-prime without an error.
    reset = 1'b1;
    @(negedge clk);
    check("rst_data", {8'h00, if_w.data}, 16'h0000);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    rd_w(3'd2, d);
    check("rst_count", {8'h00, d}, 16'h0000);
    check("reprime_err", {12'h000, if_w.err}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
